// File: rtl/debug_pkg.sv
// Shared types and register-map constants for the multi-core-capable debug controller.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_HALTED,
        ST_STEP,
        ST_XFER
    } state_t;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_ADDR     = 1;
    localparam int unsigned REG_WDATA    = 2;
    localparam int unsigned REG_STATUS   = 3;
    localparam int unsigned REG_RDATA    = 4;
    localparam int unsigned REG_BP_EN    = 5;
    localparam int unsigned REG_STAT_CLR = 6;
    localparam int unsigned REG_BP_BASE  = 8;

    localparam int unsigned CTRL_DBG_EN     = 0;
    localparam int unsigned CTRL_GO         = 1;
    localparam int unsigned CTRL_HALT_REQ   = 2;
    localparam int unsigned CTRL_STEP_MODE  = 3;
    localparam int unsigned CTRL_CMD_LSB    = 4;
    localparam int unsigned CTRL_STEP_N_LSB = 16;

    localparam int unsigned STAT_HALTED    = 0;
    localparam int unsigned STAT_BUSY      = 1;
    localparam int unsigned STAT_BP_HIT    = 2;
    localparam int unsigned STAT_BP_IDX_LSB = 4;
    localparam int unsigned STAT_REM_LSB   = 16;

    localparam logic [2:0] MODE_NOP    = 3'd0;
    localparam logic [2:0] MODE_MEM_RD = 3'd1;
    localparam logic [2:0] MODE_MEM_WR = 3'd2;
    localparam logic [2:0] MODE_REG    = 3'd3;
    localparam logic [2:0] MODE_HOLD   = 3'd4;

    function automatic logic is_xfer_cmd(input logic [2:0] cmd);
        return (cmd == 3'd1) || (cmd == 3'd2) || (cmd == 3'd5) || (cmd == 3'd6);
    endfunction

    // Transfer commands are only presented to the bridge from XFER, so HALTED holds instead.
    function automatic logic [2:0] halted_mode(input logic [2:0] cmd);
        return is_xfer_cmd(cmd) ? MODE_HOLD : cmd;
    endfunction

endpackage

// File: rtl/debug_regs_av.sv
// Avalon-MM register bank: CTRL/ADDR/WDATA/breakpoint storage and the registered readback mux.
module debug_regs_av
    import debug_pkg::*;
#(
    parameter int unsigned NUM_BP = 4,
    parameter int unsigned STEP_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              chipselect_debug,
    input  logic              write_debug,
    input  logic [31:0]       writedata_debug,
    input  logic              read_debug,
    input  logic [ADDR_W-1:0] address_debug,
    output logic [31:0]       readdata_debug,
    input  logic [31:0]       status_word,
    input  logic [31:0]       rdata_word,
    input  logic              step_mode_clr,
    input  logic              cmd_clr,
    output logic              dbg_en,
    output logic              go,
    output logic              halt_req,
    output logic              step_mode,
    output logic [2:0]        cmd,
    output logic [STEP_W-1:0] step_n,
    output logic [31:0]       addr_reg,
    output logic [31:0]       wdata_reg,
    output logic [NUM_BP-1:0] bp_en,
    output logic [31:0]       bp_addr [NUM_BP],
    output logic              stat_clr
);

    logic        wr;
    logic [31:0] ctrl_word;
    logic [31:0] rd_mux;

    assign wr       = chipselect_debug && write_debug;
    assign stat_clr = wr && (address_debug == ADDR_W'(REG_STAT_CLR)) && writedata_debug[STAT_BP_HIT];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dbg_en    <= 1'b0;
            go        <= 1'b0;
            halt_req  <= 1'b0;
            step_mode <= 1'b0;
            cmd       <= MODE_NOP;
            step_n    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            bp_en     <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
        end else begin
            go <= 1'b0;
            if (step_mode_clr) step_mode <= 1'b0;
            if (cmd_clr) cmd <= MODE_NOP;
            // Host writes come last so they override the hardware self-clears.
            if (wr) begin
                if (address_debug == ADDR_W'(REG_CTRL)) begin
                    dbg_en    <= writedata_debug[CTRL_DBG_EN];
                    go        <= writedata_debug[CTRL_GO];
                    halt_req  <= writedata_debug[CTRL_HALT_REQ];
                    step_mode <= writedata_debug[CTRL_STEP_MODE];
                    cmd       <= writedata_debug[CTRL_CMD_LSB +: 3];
                    step_n    <= writedata_debug[CTRL_STEP_N_LSB +: STEP_W];
                end
                if (address_debug == ADDR_W'(REG_ADDR))  addr_reg  <= writedata_debug;
                if (address_debug == ADDR_W'(REG_WDATA)) wdata_reg <= writedata_debug;
                if (address_debug == ADDR_W'(REG_BP_EN)) bp_en     <= writedata_debug[NUM_BP-1:0];
                for (int unsigned i = 0; i < NUM_BP; i++)
                    if (address_debug == ADDR_W'(REG_BP_BASE + i)) bp_addr[i] <= writedata_debug;
            end
        end
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_DBG_EN]                    = dbg_en;
        ctrl_word[CTRL_GO]                        = go;
        ctrl_word[CTRL_HALT_REQ]                  = halt_req;
        ctrl_word[CTRL_STEP_MODE]                 = step_mode;
        ctrl_word[CTRL_CMD_LSB +: 3]              = cmd;
        ctrl_word[CTRL_STEP_N_LSB +: STEP_W]      = step_n;

        rd_mux = '0;
        if (address_debug == ADDR_W'(REG_CTRL))   rd_mux = ctrl_word;
        if (address_debug == ADDR_W'(REG_ADDR))   rd_mux = addr_reg;
        if (address_debug == ADDR_W'(REG_WDATA))  rd_mux = wdata_reg;
        if (address_debug == ADDR_W'(REG_STATUS)) rd_mux = status_word;
        if (address_debug == ADDR_W'(REG_RDATA))  rd_mux = rdata_word;
        if (address_debug == ADDR_W'(REG_BP_EN))  rd_mux[NUM_BP-1:0] = bp_en;
        for (int unsigned i = 0; i < NUM_BP; i++)
            if (address_debug == ADDR_W'(REG_BP_BASE + i)) rd_mux = bp_addr[i];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) readdata_debug <= '0;
        else if (chipselect_debug && read_debug) readdata_debug <= rd_mux;
    end

endmodule

// File: rtl/debug_ctrl_mc.sv
// Debug controller top: run/halt/step/transfer FSM and PC breakpoint comparators.
module debug_ctrl_mc
    import debug_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned NUM_BP     = 4,
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  chipselect_debug,
    input  logic                  write_debug,
    input  logic [31:0]           writedata_debug,
    input  logic                  read_debug,
    input  logic [ADDR_W-1:0]     address_debug,
    output logic [31:0]           readdata_debug,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           data_internal,
    input  logic                  done_sending,
    input  logic                  step_ack,
    output logic                  debug,
    output logic [NUM_STAGES-1:0] enable_ext,
    output logic                  enable_pc_ext,
    output logic                  tx_flag,
    output logic [2:0]            mode,
    output logic [31:0]           address_bridged,
    output logic [31:0]           data_bridged,
    output logic                  irq_halt
);

    state_t              state;
    logic                run_en;
    logic                halt_prev;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   cnt_next;
    logic                bp_hit;
    logic [2:0]          bp_idx;
    logic [31:0]         rdata;
    logic [31:0]         status_word;

    logic                dbg_en, go, halt_req, step_mode, stat_clr;
    logic [2:0]          cmd;
    logic [STEP_W-1:0]   step_n;
    logic [NUM_BP-1:0]   bp_en;
    logic [31:0]         bp_addr [NUM_BP];

    logic                bp_any, bp_match, step_mode_clr, cmd_clr;
    logic [2:0]          bp_first;

    debug_regs_av #(
        .NUM_BP (NUM_BP),
        .STEP_W (STEP_W),
        .ADDR_W (ADDR_W)
    ) u_regs (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .chipselect_debug (chipselect_debug),
        .write_debug      (write_debug),
        .writedata_debug  (writedata_debug),
        .read_debug       (read_debug),
        .address_debug    (address_debug),
        .readdata_debug   (readdata_debug),
        .status_word      (status_word),
        .rdata_word       (rdata),
        .step_mode_clr    (step_mode_clr),
        .cmd_clr          (cmd_clr),
        .dbg_en           (dbg_en),
        .go               (go),
        .halt_req         (halt_req),
        .step_mode        (step_mode),
        .cmd              (cmd),
        .step_n           (step_n),
        .addr_reg         (address_bridged),
        .wdata_reg        (data_bridged),
        .bp_en            (bp_en),
        .bp_addr          (bp_addr),
        .stat_clr         (stat_clr)
    );

    // Descending scan so the lowest matching comparator index wins.
    always_comb begin
        bp_any   = 1'b0;
        bp_first = '0;
        for (int unsigned i = NUM_BP; i > 0; i--) begin
            if (bp_en[i-1] && (pc_in == bp_addr[i-1])) begin
                bp_any   = 1'b1;
                bp_first = 3'(i - 1);
            end
        end
    end

    // Gating uses the registered enable, so the same-cycle block has no combinational loop.
    assign bp_match      = run_en && bp_any;
    assign enable_pc_ext = run_en && !bp_any;
    assign enable_ext    = {NUM_STAGES{enable_pc_ext}};
    assign debug         = dbg_en;

    assign step_mode_clr = (state == ST_HALTED) && !is_xfer_cmd(cmd) && step_mode && (step_n != '0);
    assign cmd_clr       = (state == ST_XFER) && done_sending;
    assign cnt_next      = (step_ack && step_cnt != '0) ? step_cnt - STEP_W'(1) : step_cnt;

    always_comb begin
        status_word = '0;
        status_word[STAT_HALTED]              = (state == ST_HALTED);
        status_word[STAT_BUSY]                = (state == ST_XFER);
        status_word[STAT_BP_HIT]              = bp_hit;
        status_word[STAT_BP_IDX_LSB +: 3]     = bp_idx;
        status_word[STAT_REM_LSB +: STEP_W]   = step_cnt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_INIT;
            run_en    <= 1'b0;
            mode      <= MODE_HOLD;
            tx_flag   <= 1'b0;
            irq_halt  <= 1'b0;
            halt_prev <= 1'b0;
            step_cnt  <= '0;
            bp_hit    <= 1'b0;
            bp_idx    <= '0;
            rdata     <= '0;
        end else begin
            irq_halt  <= 1'b0;
            halt_prev <= halt_req;
            if (stat_clr) begin
                bp_hit <= 1'b0;
                bp_idx <= '0;
            end
            if (bp_match) begin
                bp_hit <= 1'b1;
                bp_idx <= bp_first;
            end
            case (state)
                ST_INIT: begin
                    run_en <= 1'b0;
                    mode   <= MODE_HOLD;
                    if (go && dbg_en) begin
                        state    <= ST_HALTED;
                        irq_halt <= 1'b1;
                        mode     <= halted_mode(cmd);
                    end else if (go) begin
                        state  <= ST_RUN;
                        run_en <= 1'b1;
                        mode   <= MODE_NOP;
                    end
                end
                ST_RUN: begin
                    if (halt_req || bp_match) begin
                        state    <= ST_HALTED;
                        run_en   <= 1'b0;
                        irq_halt <= 1'b1;
                        mode     <= halted_mode(cmd);
                    end
                end
                ST_HALTED: begin
                    if (is_xfer_cmd(cmd)) begin
                        state   <= ST_XFER;
                        mode    <= cmd;
                        tx_flag <= 1'b1;
                    end else if (step_mode && step_n != '0) begin
                        state    <= ST_STEP;
                        step_cnt <= step_n;
                        run_en   <= 1'b1;
                        mode     <= MODE_NOP;
                    end else if (!halt_req && !dbg_en) begin
                        state  <= ST_RUN;
                        run_en <= 1'b1;
                        mode   <= MODE_NOP;
                    end else begin
                        mode <= cmd;
                    end
                end
                ST_STEP: begin
                    step_cnt <= cnt_next;
                    if (bp_match || (halt_req && !halt_prev) || cnt_next == '0) begin
                        state    <= ST_HALTED;
                        run_en   <= 1'b0;
                        irq_halt <= 1'b1;
                        mode     <= halted_mode(cmd);
                    end
                end
                ST_XFER: begin
                    if (done_sending) begin
                        state    <= ST_HALTED;
                        tx_flag  <= 1'b0;
                        rdata    <= data_internal;
                        irq_halt <= 1'b1;
                        mode     <= MODE_NOP;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/debug_ctrl_mc.md
Name: debug_ctrl_mc

Overview:
- Parametrised successor to the single-core debug controller. An Avalon-MM slave register bank drives run, halt, step and memory/register transfer control for the RISC-V pipeline.
- New capabilities: NUM_BP hardware PC breakpoints, a wide step counter with remaining-count readback, a sticky status register, auto-clearing transfer commands and a halt interrupt.
- Sits between the Avalon interconnect and the core's stage-enable and debug-bridge inputs.

Parameters:
- NUM_STAGES, 4, width of enable_ext (one enable per pipeline stage).
- NUM_BP, 4, number of PC breakpoint comparators (1..8).
- STEP_W, 16, step counter width (1..16).
- ADDR_W, 4, Avalon word-address width (must be ≥ 4).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- chipselect_debug  in  1  Avalon slave select.
- write_debug  in  1  Avalon write strobe.
- writedata_debug  in  32  Avalon write data.
- read_debug  in  1  Avalon read strobe.
- address_debug  in  ADDR_W  Avalon word address.
- readdata_debug  out  32  Avalon read data, registered.
- pc_in  in  32  current core PC.
- data_internal  in  32  data returned by the bridge.
- done_sending  in  1  bridge transfer-complete pulse.
- step_ack  in  1  one instruction retired.
- debug  out  1  CTRL.DBG_EN.
- enable_ext  out  NUM_STAGES  stage enables.
- enable_pc_ext  out  1  PC enable.
- tx_flag  out  1  transfer request.
- mode  out  3  bridge command.
- address_bridged  out  32  ADDR register.
- data_bridged  out  32  WDATA register.
- irq_halt  out  1  one-cycle pulse on entry to HALTED.

Behaviour:
- Reset values: all registers 0, mode=3'b100, enables 0, tx_flag 0, irq_halt 0, readdata_debug 0, state INIT.
- Register map (word address):
  - 0 CTRL: [0] DBG_EN, [1] GO, [2] HALT_REQ, [3] STEP_MODE, [6:4] CMD, [31:16] STEP_N.
  - 1 ADDR; 2 WDATA.
  - 3 STATUS (RO): [0] halted, [1] xfer_busy, [2] bp_hit (sticky, W1C via address 6), [6:4] bp index, [31:16] steps remaining.
  - 4 RDATA (RO): latched data_internal.
  - 5 BP_EN[NUM_BP-1:0].
  - 6 STATUS clear.
  - 8+i BP_ADDR[i].
  - Unmapped addresses read 0 and ignore writes.
- Avalon: writes take effect on the next edge. Read data is valid the cycle after read_debug && chipselect_debug (fixed 1-cycle latency, no waitrequest).
- FSM states: INIT, RUN, HALTED, STEP, XFER.
  - INIT: enables 0, mode 3'b100. GO=1 with DBG_EN=0 → RUN. GO=1 with DBG_EN=1 → HALTED. GO is self-clearing.
  - RUN: enables all 1, mode 0. Goes to HALTED on HALT_REQ=1, or on bp_match = enable_pc_ext && any(BP_EN[i] && pc_in==BP_ADDR[i]).
  - Breakpoint halt: enables are gated combinationally by bp_match, so the matching instruction does not advance. bp_hit and the lowest matching index are latched.
  - HALTED: enables 0, irq_halt pulses for 1 cycle on entry.
    - CMD in {1,2,5,6} → XFER.
    - CMD in {0,3,4,7}: mode=CMD, no tx_flag.
    - STEP_MODE=1 with STEP_N≠0 → STEP; counter loads STEP_N and STEP_MODE self-clears.
    - HALT_REQ=0 with DBG_EN=0 → RUN.
  - STEP: enables 1. Counter decrements on step_ack. At 0 → HALTED. A breakpoint match or HALT_REQ rising (0→1 observed) → HALTED immediately; the remaining count is kept in STATUS.
  - XFER: mode=CMD and tx_flag=1 from the cycle after entry. On the done_sending cycle:
    - tx_flag drops and RDATA latches data_internal.
    - CMD auto-clears to 0.
    - State → HALTED.
    - Enables stay 0 throughout.
- Simultaneous events:
  - Avalon write to CTRL in the same cycle as auto-clear: the host write wins.
  - done_sending outside XFER is ignored.
  - step_ack and bp_match in the same cycle: the decrement is applied and the halt is taken.
- Widths: the step counter saturates at 0, with no wrap. STEP_N bits above STEP_W are ignored.
- Reset mid-transfer or mid-step: everything is abandoned and outputs return to reset values asynchronously.

Decomposition:
- Package debug_pkg holds:
  - the state enum;
  - register address constants;
  - CTRL/STATUS bit positions;
  - the mode encodings MODE_NOP=0 … MODE_HOLD=4.
- One sub-module, debug_regs_av: Avalon register bank, breakpoint storage and readback mux. The FSM and breakpoint comparators stay in the top level.

Test Plan:
- Reset, then write CTRL=0x2 (GO, DBG_EN=0) → next cycle enable_ext=4'hF and enable_pc_ext=1; STATUS reads 0.
- BP_ADDR0=0x40, BP_EN=1, core runs and pc_in reaches 0x40 → enable_pc_ext=0 in the same cycle, irq_halt pulses once, STATUS=0x5 (halted, bp_hit, index 0).
- Halted, write CTRL with STEP_MODE=1 and STEP_N=3 → enables high for exactly 3 step_ack pulses, then HALTED; STATUS[31:16]=0.
- Halted, write CMD=1, ADDR=0x100, WDATA=0xDEADBEEF → tx_flag=1 and mode=1. After done_sending with data_internal=0x1234: tx_flag=0, RDATA=0x1234, CTRL[6:4]=0.
- Assert RST_N low mid-XFER → tx_flag=0, mode=3'b100 and enables 0 immediately (asynchronous). After release the FSM is in INIT.
- Write 0x4 to address 6 → bp_hit clears; a read of address 7 returns 0 with 1-cycle latency.
